// File: rtl/scs8hd_o311ai_bist_pkg.sv
// Shared constants for the complex-gate BIST blocks: FSM encodings, MISR polynomial/seed,
// vector-bit field positions and a saturating counter helper.
package scs8hd_o311ai_bist_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Field positions inside the vector register {C1,B1,A3,A2,A1}
  localparam int unsigned VB_A1 = 0;
  localparam int unsigned VB_A2 = 1;
  localparam int unsigned VB_A3 = 2;
  localparam int unsigned VB_B1 = 3;
  localparam int unsigned VB_C1 = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/scs8hd_o311ai_bist_if.sv
// Handshake, cell-drive and result signals between the o311ai BIST and its host/test ring.
interface scs8hd_o311ai_bist_if;
  logic        START;
  logic        Y_IN;
  logic        A1, A2, A3, B1, C1;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [7:0]  ERR_COUNT;
  logic [4:0]  FAIL_VEC;
  logic [15:0] SIGNATURE;

  modport master (
    output START, Y_IN,
    input  A1, A2, A3, B1, C1, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC, SIGNATURE
  );

  modport slave (
    input  START, Y_IN,
    output A1, A2, A3, B1, C1, BUSY, DONE, PASS, ERR_COUNT, FAIL_VEC, SIGNATURE
  );
endinterface

// File: rtl/scs8hd_o311ai_bist_misr16.sv
// 16-bit single-input Galois MISR; reused by the complex-gate BIST blocks.
module scs8hd_bist_misr16
  import scs8hd_o311ai_bist_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] sig
);

  always_ff @(posedge CLK) begin
    if (RESET || init) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ din) ? MISR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/scs8hd_o311ai_bist.sv
// Exhaustive pattern generator / response checker for the o311ai cell:
// sweeps all 32 input vectors, compares Y, counts mismatches and compresses responses.
module scs8hd_o311ai_bist
  import scs8hd_o311ai_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PASSES    = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  scs8hd_o311ai_bist_if.slave  bus
);

  localparam logic [3:0] SCNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] PASS_LAST = 2'(NUM_PASSES - 1);

  logic [1:0] state;
  logic [4:0] vec;
  logic [3:0] scnt;
  logic [1:0] pass_cnt;
  logic       first_fail;
  logic [7:0] err_count;
  logic [4:0] fail_vec;
  logic       start_run;
  logic       capture;
  logic       exp_y;

  assign start_run = ((state == ST_IDLE) || (state == ST_DONE)) && bus.START;
  assign capture   = (state == ST_CAPTURE);
  assign exp_y     = ~((vec[VB_A1] | vec[VB_A2] | vec[VB_A3]) & vec[VB_B1] & vec[VB_C1]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      vec        <= '0;
      scnt       <= '0;
      pass_cnt   <= '0;
      first_fail <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state      <= ST_SETTLE;
            vec        <= '0;
            pass_cnt   <= '0;
            first_fail <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            scnt       <= SCNT_LOAD;
          end
        end
        ST_SETTLE: begin
          if (scnt != '0) scnt <= scnt - 4'd1;
          else            state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (bus.Y_IN != exp_y) begin
            err_count <= sat_inc8(err_count);
            if (!first_fail) begin
              fail_vec   <= vec;
              first_fail <= 1'b1;
            end
          end
          // vec stays at 31 on completion so the last vector remains on the cell in DONE
          if ((vec == 5'd31) && (pass_cnt == PASS_LAST)) begin
            state <= ST_DONE;
          end else begin
            vec   <= vec + 5'd1;
            scnt  <= SCNT_LOAD;
            state <= ST_SETTLE;
            if (vec == 5'd31) pass_cnt <= pass_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  scs8hd_bist_misr16 u_misr (
    .CLK   (CLK),
    .RESET (RESET),
    .init  (start_run),
    .en    (capture),
    .din   (bus.Y_IN),
    .sig   (bus.SIGNATURE)
  );

  assign bus.A1        = vec[VB_A1];
  assign bus.A2        = vec[VB_A2];
  assign bus.A3        = vec[VB_A3];
  assign bus.B1        = vec[VB_B1];
  assign bus.C1        = vec[VB_C1];
  assign bus.BUSY      = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign bus.DONE      = (state == ST_DONE);
  assign bus.PASS      = (state == ST_DONE) && (err_count == '0);
  assign bus.ERR_COUNT = err_count;
  assign bus.FAIL_VEC  = fail_vec;

endmodule

// File: tb/tb_scs8hd_o311ai_bist.sv
// Bench for scs8hd_o311ai_bist: default instance with selectable cell fault models,
// plus a NUM_PASSES=2 / SETTLE_CYCLES=1 instance driven with Y stuck at 1.
module tb_scs8hd_o311ai_bist;

  logic clk;
  logic rst;
  int   mode0;
  int   checks = 0;
  int   errors = 0;

  scs8hd_o311ai_bist_if bus0 ();
  scs8hd_o311ai_bist_if bus1 ();

  scs8hd_o311ai_bist dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus0)
  );

  scs8hd_o311ai_bist #(.SETTLE_CYCLES(1), .NUM_PASSES(2)) dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mode: 0 good cell, 1 stuck-at-1, 2 stuck-at-0, 3 good but inverted on vector 31
  function automatic logic cell_y(input logic [4:0] v, input int mode);
    logic good;
    good = ~((v[0] | v[1] | v[2]) & v[3] & v[4]);
    case (mode)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (v == 5'd31) ? ~good : good;
      default: return good;
    endcase
  endfunction

  function automatic logic [15:0] ref_sig(input int mode, input int passes);
    logic [15:0] s;
    logic        y;
    s = 16'hFFFF;
    for (int p = 0; p < passes; p++)
      for (int v = 0; v < 32; v++) begin
        y = cell_y(5'(v), mode);
        s = {s[14:0], 1'b0} ^ ((s[15] ^ y) ? 16'h1021 : 16'h0000);
      end
    return s;
  endfunction

  assign bus0.Y_IN = cell_y({bus0.C1, bus0.B1, bus0.A3, bus0.A2, bus0.A1}, mode0);
  assign bus1.Y_IN = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 1) bus1.START = 1'b1; else bus0.START = 1'b1;
    @(negedge clk);
    bus0.START = 1'b0;
    bus1.START = 1'b0;
  endtask

  task automatic wait_done(input int which, inout int cycles);
    while (!((which == 1) ? bus1.DONE : bus0.DONE) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_drives"}, {27'd0, bus0.C1, bus0.B1, bus0.A3, bus0.A2, bus0.A1}, 32'd0);
    chk({tag, "_busy"},   {31'd0, bus0.BUSY}, 32'd0);
    chk({tag, "_done"},   {31'd0, bus0.DONE}, 32'd0);
    chk({tag, "_pass"},   {31'd0, bus0.PASS}, 32'd0);
    chk({tag, "_err"},    {24'd0, bus0.ERR_COUNT}, 32'd0);
    chk({tag, "_fvec"},   {27'd0, bus0.FAIL_VEC}, 32'd0);
    chk({tag, "_sig"},    {16'd0, bus0.SIGNATURE}, 32'h0000FFFF);
  endtask

  typedef struct {
    int         mode;
    logic [7:0] err;
    logic [4:0] fvec;
    logic       pass;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc;
    tbl[0] = '{0, 8'd0,  5'd0,  1'b1};
    tbl[1] = '{1, 8'd7,  5'd25, 1'b0};
    tbl[2] = '{2, 8'd25, 5'd0,  1'b0};
    tbl[3] = '{3, 8'd1,  5'd31, 1'b0};

    mode0 = 0;
    bus0.START = 1'b0;
    bus1.START = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_sig1", {16'd0, bus1.SIGNATURE}, 32'h0000FFFF);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mode0 = tbl[i].mode;
      pulse_start(0);
      chk($sformatf("t%0d_busy", i), {31'd0, bus0.BUSY}, 32'd1);
      cyc = 0;
      wait_done(0, cyc);
      chk($sformatf("t%0d_latency", i), cyc, 32'd96);
      chk($sformatf("t%0d_err", i),  {24'd0, bus0.ERR_COUNT}, {24'd0, tbl[i].err});
      chk($sformatf("t%0d_fvec", i), {27'd0, bus0.FAIL_VEC}, {27'd0, tbl[i].fvec});
      chk($sformatf("t%0d_pass", i), {31'd0, bus0.PASS}, {31'd0, tbl[i].pass});
      chk($sformatf("t%0d_sig", i),  {16'd0, bus0.SIGNATURE}, {16'd0, ref_sig(tbl[i].mode, 1)});
      chk($sformatf("t%0d_vec31", i), {27'd0, bus0.C1, bus0.B1, bus0.A3, bus0.A2, bus0.A1}, 32'd31);
    end

    // START held high in DONE: rerun begins on the next edge, results identical
    mode0 = 0;
    @(negedge clk);
    bus0.START = 1'b1;
    @(negedge clk);
    chk("rerun_done_drop", {31'd0, bus0.DONE}, 32'd0);
    chk("rerun_busy", {31'd0, bus0.BUSY}, 32'd1);
    bus0.START = 1'b0;
    cyc = 0;
    // START pulsed mid-run must be ignored
    repeat (20) begin @(negedge clk); cyc++; end
    bus0.START = 1'b1;
    @(negedge clk); cyc++;
    bus0.START = 1'b0;
    wait_done(0, cyc);
    chk("rerun_latency", cyc, 32'd96);
    chk("rerun_pass", {31'd0, bus0.PASS}, 32'd1);
    chk("rerun_err", {24'd0, bus0.ERR_COUNT}, 32'd0);
    chk("rerun_sig", {16'd0, bus0.SIGNATURE}, {16'd0, ref_sig(0, 1)});

    // Reset at cycle 40 of a stuck-at-0 run
    mode0 = 2;
    pulse_start(0);
    repeat (40) @(negedge clk);
    chk("abort_err_pre", {24'd0, bus0.ERR_COUNT}, 32'd13);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", {31'd0, bus0.BUSY}, 32'd0);

    // Two passes, one settle cycle, Y stuck at 1
    pulse_start(1);
    cyc = 0;
    wait_done(1, cyc);
    chk("p2_latency", cyc, 32'd128);
    chk("p2_err", {24'd0, bus1.ERR_COUNT}, 32'd14);
    chk("p2_fvec", {27'd0, bus1.FAIL_VEC}, 32'd25);
    chk("p2_pass", {31'd0, bus1.PASS}, 32'd0);
    chk("p2_sig", {16'd0, bus1.SIGNATURE}, {16'd0, ref_sig(1, 2)});
    repeat (3) @(negedge clk);
    chk("p2_done_hold", {31'd0, bus1.DONE}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
